// File: rtl/xadc_joy_sequencer.sv
// xadc_joy_sequencer: alternating X/Y XADC DRP reader with per-axis offset trim and clamp.
// Define XADC_AVG_EN to average 2^AVG_LOG2 raw samples per axis before publishing.
module xadc_joy_sequencer #(
  parameter logic [6:0]         CH_X_ADDR = 7'h1b,
  parameter logic [6:0]         CH_Y_ADDR = 7'h1a,
  parameter logic signed [12:0] X_OFFSET  = -13'sd8,
  parameter logic signed [12:0] Y_OFFSET  = 13'sd24,
  parameter int                 TIMEOUT   = 255,
  parameter int                 AVG_LOG2  = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        eoc_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic        den_out,
  output logic [6:0]  daddr_out,
  output logic [11:0] x_joy,
  output logic [11:0] y_joy,
  output logic        x_valid,
  output logic        y_valid,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;
  logic ch_q, ch_d, den_q, den_d, xv_q, xv_d, yv_q, yv_d, terr_q, terr_d;
  logic [6:0] addr_q, addr_d;
  logic [11:0] x_q, x_d, y_q, y_d, sample, val;
  logic [TW-1:0] cnt_q, cnt_d;
  logic fire, cap;

  assign sample = do_in[15:4];
  assign cap = (state_q == WAIT) && drdy_in;

  // 14-bit sum keeps both underflow (bit 13) and overflow past 4095 (bit 12) visible for clamping
  function automatic logic [11:0] trim(input logic [11:0] v, input logic [12:0] off);
    logic [13:0] s;
    s = {2'b00, v} + {off[12], off};
    return s[13] ? 12'd0 : s[12] ? 12'hfff : s[11:0];
  endfunction

`ifdef XADC_AVG_EN
  logic [11+AVG_LOG2:0] acc_q [2];
  logic [11+AVG_LOG2:0] acc_d [2];
  logic [11+AVG_LOG2:0] sum;
  logic [AVG_LOG2-1:0] n_q [2];
  logic [AVG_LOG2-1:0] n_d [2];
  assign sum = acc_q[ch_q] + {{AVG_LOG2{1'b0}}, sample};
  assign fire = &n_q[ch_q];
  assign val = 12'(sum >> AVG_LOG2);
  always_comb begin
    acc_d = acc_q;
    n_d = n_q;
    if (cap) begin
      acc_d[ch_q] = fire ? '0 : sum;
      n_d[ch_q] = n_q[ch_q] + 1'b1;
    end
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '{default: '0};
      n_q <= '{default: '0};
    end else begin
      acc_q <= acc_d;
      n_q <= n_d;
    end
  end
`else
  assign fire = 1'b1;
  assign val = sample;
`endif

  // Capture is registered straight out of WAIT so outputs land one cycle after drdy_in
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    den_d = 1'b0;
    xv_d = 1'b0;
    yv_d = 1'b0;
    x_d = x_q;
    y_d = y_q;
    terr_d = terr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (eoc_in) begin
        state_d = REQ;
        den_d = 1'b1;
      end
      REQ: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (drdy_in) begin
        state_d = CAPT;
        ch_d = ~ch_q;
        xv_d = fire && !ch_q;
        yv_d = fire && ch_q;
        x_d = (fire && !ch_q) ? trim(val, X_OFFSET) : x_q;
        y_d = (fire && ch_q) ? trim(val, Y_OFFSET) : y_q;
      end else if (cnt_q == TW'(TIMEOUT)) begin
        state_d = IDLE;
        terr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    addr_d = ch_d ? CH_Y_ADDR : CH_X_ADDR;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q <= 1'b0;
      den_q <= 1'b0;
      xv_q <= 1'b0;
      yv_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      terr_q <= 1'b0;
      cnt_q <= '0;
      addr_q <= CH_X_ADDR;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      den_q <= den_d;
      xv_q <= xv_d;
      yv_q <= yv_d;
      x_q <= x_d;
      y_q <= y_d;
      terr_q <= terr_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
    end
  end

  assign den_out = den_q;
  assign daddr_out = addr_q;
  assign x_joy = x_q;
  assign y_joy = y_q;
  assign x_valid = xv_q;
  assign y_valid = yv_q;
  assign timeout_err = terr_q;
endmodule
